// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stage.
// Build option: UART_TX_PARITY_EN adds an even-parity bit (8E1 frames).
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/uart_tx_stage_if.sv
// Byte write handshake from the core into the UART transmit stage.
interface uart_tx_stage_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; full/empty/count are registered and derived from the count.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [CW-1:0]    count_d;

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    count_d = count + CW'(do_push) - CW'(do_pop);
  end

  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_stage.sv
// UART transmit stage: buffered bytes go out as 8N1 frames (8E1 with UART_TX_PARITY_EN).
// FSM, shift register and baud counter live here; buffering is in uart_tx_fifo.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  uart_tx_stage_if.slave              bus,
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [BAUD_W-1:0]         baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_out_d;
  logic                      busy_d;
  logic                      bit_end;
  logic                      start_ok;
  logic                      pop_c;
  logic                      push_c;
  logic [UART_DATA_BITS-1:0] fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign push_c       = bus.tx_valid && !fifo_full;
  assign bus.tx_ready = !fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (bus.tx_data),
    .pop       (pop_c),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state, datapath updates and next line level.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop_c    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_end  = (baud_q == BAUD_LAST);
    start_ok = ena && !fifo_empty;
    baud_d   = bit_end ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (start_ok) begin
          state_d = ST_START;
          pop_c   = 1'b1;
          shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          parity_d = even_parity(fifo_rd_data);
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (start_ok) begin
            // Back-to-back frame: no idle bit between STOP and the next START.
            state_d = ST_START;
            pop_c   = 1'b1;
            shift_d = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
            parity_d = even_parity(fifo_rd_data);
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) baud_d = '0;

    tx_out_d = UART_IDLE_LEVEL;
    case (state_d)
      ST_START:  tx_out_d = ~UART_IDLE_LEVEL;
      ST_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      default:   tx_out_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_out   <= UART_IDLE_LEVEL;
      busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_out   <= tx_out_d;
      busy     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Scoreboard bench for uart_tx_stage: accepted bytes queue expected frames, a line monitor decodes and compares.
module tb_uart_tx_stage;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_CYC = FRAME_BITS * CPB;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       tx_out;
  logic       busy;
  logic [2:0] fifo_count;

  uart_tx_stage_if bus();

  uart_tx_stage #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .bus        (bus),
    .tx_out     (tx_out),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cycles = 0;
  int n_starts = 0;
  int peak = 0;
  logic last_par = 1'b0;
  logic [7:0] exp_q [$];
  int starts [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready must mirror "FIFO not full" every cycle; also track peak occupancy.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ready_vs_full", 32'(bus.tx_ready), 32'(fifo_count != 3'(DEPTH)));
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  // Line monitor: capture a whole frame, then compare against the expected byte.
  logic line_s [FRAME_CYC];
  logic busy_s [FRAME_CYC];
  bit   in_frame = 1'b0;
  int   fcyc = 0;

  always @(negedge clk) begin
    if (rst || cyc == 0) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx_out === 1'b0) begin
        in_frame = 1'b1;
        fcyc = 0;
        n_starts++;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        line_s[fcyc] = tx_out;
        busy_s[fcyc] = busy;
        fcyc++;
        if (fcyc == int'(FRAME_CYC)) begin
          logic [7:0] e;
          logic [7:0] got;
          logic       want;
          int         bad;
          in_frame = 1'b0;
          for (int k = 0; k < 8; k++) got[k] = line_s[(k + 1) * CPB + CPB / 2];
          if (FRAME_BITS == 11) last_par = line_s[9 * CPB + CPB / 2];
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            bad = 0;
            for (int c = 0; c < int'(FRAME_CYC); c++) begin
              int k;
              k = c / int'(CPB);
              if (k == 0) want = 1'b0;
              else if (k <= 8) want = e[k - 1];
              else if (k == 9 && FRAME_BITS == 11) want = ^e;
              else want = 1'b1;
              if (line_s[c] !== want || busy_s[c] !== 1'b1) bad++;
            end
            chk("frame_byte", 32'(got), 32'(e));
            chk("frame_waveform_bad_cycles", 32'(bad), 32'd0);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one byte and wait (bounded) for acceptance; the expected frame is queued on acceptance.
  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      logic r;
      @(negedge clk);
      r = bus.tx_ready;
      if (!r) stall_cycles++;
      @(posedge clk);
      if (r) begin
        exp_q.push_back(b);
        done = 1'b1;
      end
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_count === 3'd0) ok = 1'b1;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    tick(1);
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1;
    ena = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    // Reset values.
    tick(3);
    @(negedge clk);
    chk("rst_tx_out", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Single byte: latency and frame length.
    send(8'hA5);
    @(negedge clk);
    chk("lat_count_after_accept", 32'(fifo_count), 32'd1);
    chk("lat_line_still_idle", 32'(tx_out), 32'd1);
    @(negedge clk);
    chk("lat_start_low", 32'(tx_out), 32'd0);
    chk("lat_busy_high", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_length", 32'(n), 32'(FRAME_CYC));
    wait_idle(100);

    // Back-to-back frames with no idle gap.
    peak = 0;
    starts.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    wait_idle(400);
    chk("b2b_peak_count", 32'(peak), 32'd2);
    chk("b2b_frames", 32'(starts.size()), 32'd3);
    if (starts.size() == 3) begin
      chk("b2b_gap_1", 32'(starts[1] - starts[0]), 32'(FRAME_CYC));
      chk("b2b_gap_2", 32'(starts[2] - starts[1]), 32'(FRAME_CYC));
    end

    // Overflow: six bytes held against a four-entry FIFO.
    stall_cycles = 0;
    for (int i = 0; i < 6; i++) send(8'($urandom));
    chk("full_stall_cycles", 32'(stall_cycles), 32'(FRAME_CYC - 3));
    wait_idle(800);

    // Reset mid-DATA with two bytes queued.
    send(8'h55);
    send(8'h12);
    send(8'h34);
    tick(12);
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd2);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx_out", 32'(tx_out), 32'd1);
    chk("midrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    s0 = n_starts;
    tick(100);
    chk("midrst_no_frames", 32'(n_starts - s0), 32'd0);

    // ena low holds queued bytes; raising it releases them.
    ena = 1'b0;
    s0 = n_starts;
    send(8'hC3);
    send(8'h5A);
    tick(20);
    @(negedge clk);
    chk("ena0_line_idle", 32'(tx_out), 32'd1);
    chk("ena0_busy", 32'(busy), 32'd0);
    chk("ena0_fifo_count", 32'(fifo_count), 32'd2);
    chk("ena0_no_frames", 32'(n_starts - s0), 32'd0);
    @(posedge clk);
    #1 ena = 1'b1;
    wait_idle(400);
    chk("ena1_frames", 32'(n_starts - s0), 32'd2);

`ifdef UART_TX_PARITY_EN
    // Even parity bit values.
    send(8'h07);
    wait_idle(200);
    chk("parity_07", 32'(last_par), 32'd1);
    send(8'h03);
    wait_idle(200);
    chk("parity_03", 32'(last_par), 32'd0);
`endif

    // Random bytes with random gaps.
    for (int i = 0; i < 12; i++) begin
      tick($urandom_range(0, 50));
      send(8'($urandom));
    end
    wait_idle(2000);
    chk("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_stage.md
# uart_tx_stage

Serial output stage downstream of the SummerTinyTapeout core. Accepts bytes from the core over a valid/ready handshake and buffers them in a small FIFO. Each byte goes out as an 8N1 UART frame (optionally 8E1) on a single pin, which the top level routes to `uo_out[0]`. Gives the tile a host-readable debug/data channel without the core managing bit timing.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — clock cycles per serial bit (50 MHz / 115200 baud); legal range ≥ 2.
- `FIFO_DEPTH`, default 4 — byte entries; power of two, 2..16.

Ports:
- `clk` — in, 1 — single clock; all state changes on its rising edge.
- `rst` — in, 1 — reset, synchronous and active-high; the top level drives it as `~rst_n`.
- `ena` — in, 1 — tile enable; gates frame start only.
- `tx_data` — in, 8 — byte to send.
- `tx_valid` — in, 1 — `tx_data` valid.
- `tx_ready` — out, 1 — FIFO can accept; high iff FIFO not full.
- `tx_out` — out, 1 — serial line, idle high; registered.
- `busy` — out, 1 — high while a frame is on the line (START..STOP).
- `fifo_count` — out, $clog2(FIFO_DEPTH)+1 — entries currently buffered.

## Operation
- Write is accepted on an edge where `tx_valid && tx_ready`. `tx_data` must hold while `tx_valid` is high and `tx_ready` is low.
- FSM states: IDLE, START, DATA, PARITY (only with `UART_TX_PARITY_EN`), STOP.
- IDLE: `tx_out`=1. If the FIFO is non-empty and `ena`=1, pop the head into the shift register and go to START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: send 8 bits LSB first, `CLKS_PER_BIT` cycles each. A 3-bit counter tracks the bit; after bit 7, go to PARITY or STOP.
- PARITY: `tx_out` = XOR of the 8 data bits (even parity), then STOP.
- STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty and `ena`=1, pop and go straight to START with no extra idle bit. Otherwise go to IDLE.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1, clears on every state transition, and wraps with no drift.
- `ena` low: a frame in progress completes normally, no new frame starts, and writes are still accepted.
- Full FIFO: `tx_ready`=0 even on a cycle where a pop occurs; there is no combinational bypass. An attempted write is ignored and nothing is corrupted.
- Simultaneous push and pop on a non-full FIFO: both take effect and `fifo_count` is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`. Full/empty is decided by `fifo_count`.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `tx_ready`=1, `fifo_count`=0, FSM=IDLE.
- `rst` mid-frame: on the next edge, `tx_out`=1, the FSM goes to IDLE, and the FIFO is flushed. The truncated frame is never resumed.
- Latency into an empty, idle block with `ena`=1:
  - Write accepted at edge N.
  - `fifo_count`=1 after edge N.
  - Pop at edge N+1; `tx_out`=0 and `busy`=1 after edge N+1.
- Frame length: 10 (or 11 with parity) × `CLKS_PER_BIT` cycles from the falling start edge to the end of STOP.
- `busy` falls on the same edge the FSM enters IDLE.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: the PARITY state exists, and frames are 8E1 (11 bit periods).
- Undefined: the PARITY state and parity logic are absent, and frames are 8N1 (10 bit periods).

## Structure
- Shared package `uart_pkg`: the FSM state enum typedef, the `UART_IDLE_LEVEL` constant (1'b1), and `UART_DATA_BITS` (8).
- Sub-module `uart_tx_fifo`: a synchronous byte FIFO with push/pop/count/full/empty.
- The FSM, shift register, and baud counter live in `uart_tx_stage`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset, then write 0xA5 → `tx_out` reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Start goes low 1 edge after acceptance, and `busy` falls after 40 cycles.
- Write 0x00, 0xFF, 0x3C back-to-back → three frames with no idle gap; `fifo_count` peaks at 2 and then drains to 0.
- Hold `tx_valid` with 6 bytes while the line is busy → `tx_ready` drops once 4 entries are buffered. The excess bytes are sent only after re-acceptance, and all 6 go out in order.
- Assert `rst` mid-DATA of 0x55 with 2 bytes queued → next edge `tx_out`=1, `fifo_count`=0, `busy`=0, and no further frames.
- `ena`=0 with 2 bytes queued → the line stays idle high and `fifo_count`=2. Raise `ena` → both frames are sent.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit = 1 and the frame is 44 cycles long. Write 0x03 → parity bit = 0.
